dsp48a1: RTL and testbench
==========================

DSP48A1 -- requirements
Module: dsp48a1

Interface
REQ-001 Parameter A0REG, default 0, 1 = register A at first stage, 0 = bypass.
REQ-002 Parameter A1REG, default 1, 1 = register A at second stage, 0 = bypass.
REQ-003 Parameter B0REG, default 0, 1 = register B at first stage, 0 = bypass.
REQ-004 Parameter B1REG, default 1, 1 = register B at second stage, 0 = bypass.
REQ-005 Parameters CREG, DREG, MREG, PREG, CARRYINREG, CARRYOUTREG, OPMODEREG, each default 1, 1 = register, 0 = bypass.
REQ-006 Parameter CARRYINSEL, default "OPMODE5", selects the carry-in source: "OPMODE5" or "CARRYIN".
REQ-007 Parameter B_INPUT, default "DIRECT", selects the B source: "DIRECT" = port B, "CASCADE" = port BCIN.
REQ-008 Ports: clk in 1 (single clock, rising edge); rstA/rstB/rstC/rstD/rstM/rstP/rstcarryin/rstopmode in 1 each (per-register resets, synchronous, active-high).
REQ-009 Ports: A, B, D in 18 (data); BCIN in 18 (B cascade in); C in 48; PCIN in 48 (P cascade in); carryin in 1; opmode in 8.
REQ-010 Ports: ceA/ceB/ceC/ceD/ceM/ceP/cecarryin/ceopmode in 1 each (clock enables, active-high).
REQ-011 Ports: M out 36; P out 48; carryout out 1; carryoutF out 1; BCOUT out 18; PCOUT out 48.
REQ-012 Positional port order SHALL be: A, B, BCIN, C, D, carryin, M, P, carryout, carryoutF, clk, opmode, ceA, ceB, ceC, cecarryin, ceD, ceM, ceopmode, ceP, rstA, rstB, rstC, rstcarryin, rstD, rstM, rstopmode, rstP, BCOUT, PCIN, PCOUT.

Function
REQ-013 Each pipeline register SHALL load on the clk rising edge when its ce is 1 and hold otherwise; when its xREG parameter is 0 it SHALL be a combinational pass-through.
REQ-014 The pre-adder SHALL compute D+B0 when opmode[6]=0 and D−B0 when opmode[6]=1, as an 18-bit result that wraps modulo 2^18.
REQ-015 The B1 stage input SHALL be the pre-adder result when opmode[4]=1 and B0 when opmode[4]=0; BCOUT = B1 stage output.
REQ-016 M SHALL be the unsigned 36-bit product A1×B1, registered per MREG.
REQ-017 X mux, selected by opmode[1:0]: 0 → 0; 1 → M zero-extended to 48 bits; 2 → P; 3 → {D[11:0], A1, B1}.
REQ-018 Z mux, selected by opmode[3:2]: 0 → 0; 1 → PCIN; 2 → P; 3 → C.
REQ-019 Carry-in SHALL be opmode[5] or the carryin port, per CARRYINSEL, registered per CARRYINREG (CYI).
REQ-020 Post-adder: Z+X+CYI when opmode[7]=0, Z−(X+CYI) when opmode[7]=1, computed in 49 bits; bits [47:0] → P register, bit 48 → carryout register.
REQ-021 carryoutF SHALL equal carryout, and PCOUT SHALL equal P.
REQ-022 All opmode uses SHALL take the OPMODEREG stage output.
REQ-023 With default parameters, latency SHALL be: A/B/D→M 2 clocks; A/B/D→P 3 clocks; C→P 2 clocks; B→BCOUT 1 clock, or 2 with DREG when the pre-adder is used.

Reset
REQ-024 Each rstX SHALL clear only its own register group to 0 on the clk edge, and rstX SHALL take priority over ceX.
REQ-025 When all resets are asserted, M, P, PCOUT, BCOUT, carryout and carryoutF SHALL read 0 after one clock, regardless of the ce values.
REQ-026 Deasserting a reset mid-operation SHALL resume normal loading on the next enabled edge; no other state is affected.

Structure
REQ-027 A shared package SHALL hold the opmode field positions, the X/Z mux encodings and the CARRYINSEL/B_INPUT string constants.
REQ-028 One sub-module, dsp_reg_mux (parameterised width, register enable/bypass, clk, ce, rst), SHALL implement every pipeline stage.

Verification
REQ-029 Reset: all rst=1, random ce and data for 50 clocks → every output is 0 at each negedge.
REQ-030 Pre-add/multiply: A=2, B=1, D=1, C=0, carryin=0, opmode=0x11, all ce=1, held for 4 clocks → BCOUT=2, M=4, P=4, PCOUT=4.
REQ-031 Concatenation: A=0, B=5, D=0, opmode=0x03, held 4 clocks → P=5.
REQ-032 Subtract: A=3, B=4, C=100, opmode=0x8D, held 4 clocks → M=12, P=88.
REQ-033 Accumulate: A=1, B=1, opmode=0x09, after the pipeline fills → P increments by 1 each clock; ceP=0 freezes P.
REQ-034 Carry: C=48'hFFFF_FFFF_FFFF, opmode=0x2C (Z=C, X=0, opmode[5]=1 with CARRYINSEL="OPMODE5") → P=0, carryout=1, carryoutF=1.

Source files
------------

// File: rtl/dsp48a1_pkg.sv
// dsp48a1_pkg: shared opmode field positions, X/Z mux encodings and source-select strings
package dsp48a1_pkg;
    localparam int OP_X_LSB = 0;
    localparam int OP_Z_LSB = 2;
    localparam int OP_PRE_EN = 4;
    localparam int OP_CARRY = 5;
    localparam int OP_PRE_SUB = 6;
    localparam int OP_POST_SUB = 7;
    localparam logic [1:0] X_ZERO = 2'd0;
    localparam logic [1:0] X_M = 2'd1;
    localparam logic [1:0] X_P = 2'd2;
    localparam logic [1:0] X_DAB = 2'd3;
    localparam logic [1:0] Z_ZERO = 2'd0;
    localparam logic [1:0] Z_PCIN = 2'd1;
    localparam logic [1:0] Z_P = 2'd2;
    localparam logic [1:0] Z_C = 2'd3;
    localparam string SEL_OPMODE5 = "OPMODE5";
    localparam string SEL_CARRYIN = "CARRYIN";
    localparam string B_DIRECT = "DIRECT";
    localparam string B_CASCADE = "CASCADE";
endpackage

// File: rtl/dsp48a1_reg_mux.sv
// dsp_reg_mux: one pipeline stage, registered (REG=1) or combinational pass-through (REG=0)
//   clk, rst (sync, active-high, wins over ce), ce (load enable), d -> q (W bits)
module dsp_reg_mux #(
    parameter int W = 18,
    parameter int REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] r;
    always_ff @(posedge clk)
        if (rst) r <= '0;
        else if (ce) r <= d;
    assign q = (REG != 0) ? r : d;
endmodule

// File: rtl/dsp48a1.sv
// dsp48a1: pre-adder / 18x18 multiplier / 48-bit post-adder slice with configurable pipeline
//   A, B, D, BCIN (18) data in; C, PCIN (48); carryin; opmode (8)
//   ceX / rstX per register group (sync, active-high, rst wins)
//   M (36) product; P, PCOUT (48) result; carryout, carryoutF; BCOUT (18) B1 stage
module dsp48a1 import dsp48a1_pkg::*; #(
    parameter int A0REG = 0,
    parameter int A1REG = 1,
    parameter int B0REG = 0,
    parameter int B1REG = 1,
    parameter int CREG = 1,
    parameter int DREG = 1,
    parameter int MREG = 1,
    parameter int PREG = 1,
    parameter int CARRYINREG = 1,
    parameter int CARRYOUTREG = 1,
    parameter int OPMODEREG = 1,
    parameter string CARRYINSEL = SEL_OPMODE5,
    parameter string B_INPUT = B_DIRECT
) (
    input  logic [17:0] A,
    input  logic [17:0] B,
    input  logic [17:0] BCIN,
    input  logic [47:0] C,
    input  logic [17:0] D,
    input  logic        carryin,
    output logic [35:0] M,
    output logic [47:0] P,
    output logic        carryout,
    output logic        carryoutF,
    input  logic        clk,
    input  logic [7:0]  opmode,
    input  logic        ceA,
    input  logic        ceB,
    input  logic        ceC,
    input  logic        cecarryin,
    input  logic        ceD,
    input  logic        ceM,
    input  logic        ceopmode,
    input  logic        ceP,
    input  logic        rstA,
    input  logic        rstB,
    input  logic        rstC,
    input  logic        rstcarryin,
    input  logic        rstD,
    input  logic        rstM,
    input  logic        rstopmode,
    input  logic        rstP,
    output logic [17:0] BCOUT,
    input  logic [47:0] PCIN,
    output logic [47:0] PCOUT
);
    logic [7:0] opm;
    logic [17:0] a0, a1, b0, b1, d_q, b_src, pre, b1_in;
    logic [35:0] m_q;
    logic [47:0] c_q, p_q, x, z;
    logic cyi_in, cyi, co_q;
    logic [48:0] post;

    dsp_reg_mux #(.W(8), .REG(OPMODEREG)) u_op (.clk(clk), .rst(rstopmode), .ce(ceopmode), .d(opmode), .q(opm));

    assign b_src = (B_INPUT == B_CASCADE) ? BCIN : B;
    dsp_reg_mux #(.W(18), .REG(A0REG)) u_a0 (.clk(clk), .rst(rstA), .ce(ceA), .d(A), .q(a0));
    dsp_reg_mux #(.W(18), .REG(A1REG)) u_a1 (.clk(clk), .rst(rstA), .ce(ceA), .d(a0), .q(a1));
    dsp_reg_mux #(.W(18), .REG(B0REG)) u_b0 (.clk(clk), .rst(rstB), .ce(ceB), .d(b_src), .q(b0));
    dsp_reg_mux #(.W(18), .REG(DREG)) u_d (.clk(clk), .rst(rstD), .ce(ceD), .d(D), .q(d_q));

    assign pre = opm[OP_PRE_SUB] ? d_q - b0 : d_q + b0;
    assign b1_in = opm[OP_PRE_EN] ? pre : b0;
    dsp_reg_mux #(.W(18), .REG(B1REG)) u_b1 (.clk(clk), .rst(rstB), .ce(ceB), .d(b1_in), .q(b1));
    assign BCOUT = b1;

    dsp_reg_mux #(.W(36), .REG(MREG)) u_m (.clk(clk), .rst(rstM), .ce(ceM), .d(36'(a1) * 36'(b1)), .q(m_q));
    assign M = m_q;

    dsp_reg_mux #(.W(48), .REG(CREG)) u_c (.clk(clk), .rst(rstC), .ce(ceC), .d(C), .q(c_q));

    assign cyi_in = (CARRYINSEL == SEL_CARRYIN) ? carryin : opm[OP_CARRY];
    dsp_reg_mux #(.W(1), .REG(CARRYINREG)) u_cyi (.clk(clk), .rst(rstcarryin), .ce(cecarryin), .d(cyi_in), .q(cyi));

    always_comb begin
        x = (opm[OP_X_LSB +: 2] == X_ZERO) ? 48'd0 :
            (opm[OP_X_LSB +: 2] == X_M) ? {12'd0, m_q} :
            (opm[OP_X_LSB +: 2] == X_P) ? p_q : {d_q[11:0], a1, b1};
        z = (opm[OP_Z_LSB +: 2] == Z_ZERO) ? 48'd0 :
            (opm[OP_Z_LSB +: 2] == Z_PCIN) ? PCIN :
            (opm[OP_Z_LSB +: 2] == Z_P) ? p_q : c_q;
        post = opm[OP_POST_SUB] ? {1'b0, z} - ({1'b0, x} + 49'(cyi)) : {1'b0, z} + {1'b0, x} + 49'(cyi);
    end

    dsp_reg_mux #(.W(48), .REG(PREG)) u_p (.clk(clk), .rst(rstP), .ce(ceP), .d(post[47:0]), .q(p_q));
    // carry-out register shares the carry-in group's enable and reset
    dsp_reg_mux #(.W(1), .REG(CARRYOUTREG)) u_co (.clk(clk), .rst(rstcarryin), .ce(cecarryin), .d(post[48]), .q(co_q));

    assign P = p_q;
    assign PCOUT = p_q;
    assign carryout = co_q;
    assign carryoutF = co_q;
endmodule

// File: tb/tb_dsp48a1.sv
// tb_dsp48a1: directed-vector self-checking bench for dsp48a1 with default parameters
module tb_dsp48a1;
    logic [17:0] A, B, BCIN, D, BCOUT;
    logic [47:0] C, P, PCIN, PCOUT;
    logic [35:0] M;
    logic [7:0] opmode;
    logic clk = 1'b0, carryin, carryout, carryoutF;
    logic ceA, ceB, ceC, cecarryin, ceD, ceM, ceopmode, ceP;
    logic rstA, rstB, rstC, rstcarryin, rstD, rstM, rstopmode, rstP;
    int nvec = 0, nerr = 0;

    dsp48a1 dut (
        .A(A), .B(B), .BCIN(BCIN), .C(C), .D(D), .carryin(carryin),
        .M(M), .P(P), .carryout(carryout), .carryoutF(carryoutF),
        .clk(clk), .opmode(opmode),
        .ceA(ceA), .ceB(ceB), .ceC(ceC), .cecarryin(cecarryin), .ceD(ceD), .ceM(ceM), .ceopmode(ceopmode), .ceP(ceP),
        .rstA(rstA), .rstB(rstB), .rstC(rstC), .rstcarryin(rstcarryin), .rstD(rstD), .rstM(rstM), .rstopmode(rstopmode), .rstP(rstP),
        .BCOUT(BCOUT), .PCIN(PCIN), .PCOUT(PCOUT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_rst(input logic v);
        {rstA, rstB, rstC, rstcarryin, rstD, rstM, rstopmode, rstP} = {8{v}};
    endtask

    task automatic set_ce(input logic [7:0] v);
        {ceA, ceB, ceC, cecarryin, ceD, ceM, ceopmode, ceP} = v;
    endtask

    initial begin
        BCIN = '0; PCIN = '0; carryin = 1'b0;
        set_rst(1'b1);
        for (int i = 0; i < 50; i++) begin
            set_ce(8'($urandom));
            A = 18'($urandom); B = 18'($urandom); D = 18'($urandom);
            C = {16'($urandom), 32'($urandom)}; PCIN = {16'($urandom), 32'($urandom)};
            carryin = 1'($urandom); opmode = 8'($urandom);
            tick(1);
            chk("rst_M", 48'(M), 48'd0);
            chk("rst_P", P, 48'd0);
            chk("rst_PCOUT", PCOUT, 48'd0);
            chk("rst_BCOUT", 48'(BCOUT), 48'd0);
            chk("rst_co", 48'(carryout), 48'd0);
            chk("rst_coF", 48'(carryoutF), 48'd0);
        end
        set_rst(1'b0);
        set_ce(8'hFF);
        PCIN = '0; carryin = 1'b0;
        A = 18'd2; B = 18'd1; D = 18'd1; C = 48'd0; opmode = 8'h11;
        tick(4);
        chk("preadd_BCOUT", 48'(BCOUT), 48'd2);
        chk("preadd_M", 48'(M), 48'd4);
        chk("preadd_P", P, 48'd4);
        chk("preadd_PCOUT", PCOUT, 48'd4);
        A = 18'd0; B = 18'd5; D = 18'd0; opmode = 8'h03;
        tick(4);
        chk("concat_P", P, 48'd5);
        chk("concat_BCOUT", 48'(BCOUT), 48'd5);
        A = 18'd3; B = 18'd4; C = 48'd100; opmode = 8'h8D;
        tick(4);
        chk("sub_M", 48'(M), 48'd12);
        chk("sub_P", P, 48'd88);
        chk("sub_co", 48'(carryout), 48'd0);
        A = 18'd1; B = 18'd1; C = 48'd0; opmode = 8'h09; rstP = 1'b1;
        tick(4);
        chk("acc_rst_P", P, 48'd0);
        chk("acc_M", 48'(M), 48'd1);
        rstP = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            chk("acc_P", P, 48'(k));
        end
        ceP = 1'b0;
        tick(2);
        chk("acc_hold_P", P, 48'd3);
        ceP = 1'b1;
        C = 48'hFFFF_FFFF_FFFF; opmode = 8'h2C;
        tick(4);
        chk("carry_P", P, 48'd0);
        chk("carry_co", 48'(carryout), 48'd1);
        chk("carry_coF", 48'(carryoutF), 48'd1);
        rstcarryin = 1'b1;
        tick(1);
        chk("rstcy_co", 48'(carryout), 48'd0);
        chk("rstcy_P", P, 48'd0);
        rstcarryin = 1'b0;
        tick(1);
        chk("nocy_P", P, 48'hFFFF_FFFF_FFFF);
        chk("nocy_co", 48'(carryout), 48'd0);
        tick(1);
        chk("cy_back_co", 48'(carryout), 48'd1);
        A = 18'd2; B = 18'd3; D = 18'd10; C = 48'd0; opmode = 8'h51;
        tick(4);
        chk("presub_BCOUT", 48'(BCOUT), 48'd7);
        chk("presub_P", P, 48'd14);
        A = 18'd3; B = 18'd4; D = 18'd0; PCIN = 48'd1000; opmode = 8'h05;
        tick(4);
        chk("pcin_P", P, 48'd1012);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
